// File: rtl/ddp_inj_pkg.sv
// Shared definitions for the DDP button injector: FSM states, packet layout and
// the packing helper used when an event is queued.
package ddp_inj_pkg;

    localparam int BTN_W    = 4;
    localparam int SEQ_W    = 8;
    localparam int PKT_W    = 16;

    localparam int SEQ_MSB  = 15;
    localparam int SEQ_LSB  = 8;
    localparam int MASK_MSB = 7;
    localparam int MASK_LSB = 4;
    localparam int LVL_MSB  = 3;
    localparam int LVL_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_RELEASE = 2'd2
    } inj_state_e;

    // Builds the bundled-data word {seq, changed mask, new level}.
    function automatic logic [PKT_W-1:0] pack_pkt(
        input logic [SEQ_W-1:0] seq,
        input logic [BTN_W-1:0] mask,
        input logic [BTN_W-1:0] lvl
    );
        logic [PKT_W-1:0] pkt;
        pkt                    = {PKT_W{1'b0}};
        pkt[SEQ_MSB:SEQ_LSB]   = seq;
        pkt[MASK_MSB:MASK_LSB] = mask;
        pkt[LVL_MSB:LVL_LSB]   = lvl;
        return pkt;
    endfunction

endpackage

// File: rtl/ddp_inj_fifo.sv
// Event buffer for the injector: synchronous FIFO, power-of-2 depth, with a
// same-cycle push+pop accepted even when full (the popped slot is reused).
module ddp_inj_fifo
    import ddp_inj_pkg::*;
#(
    parameter int WIDTH = PKT_W,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             do_pop_s;
    logic             do_push_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign head      = mem_r[rd_ptr_r[AW-1:0]];

    // Read/write pointers with one wrap bit to tell full from empty.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage array; entries are only read after being written.
    always_ff @(posedge CLK) begin
        if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ddp_btn_injector.sv
// Turns button level changes into DDP packets sent over a 4-phase Send/Ack channel.
// Optional handshake timeout is enabled by defining DDP_INJ_TIMEOUT_EN.
module ddp_btn_injector
    import ddp_inj_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_SYNC    = 2,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [BTN_W-1:0] BTN_LVL,
    input  logic             Ack_in_DDP,
    output logic             Send_in_DDP,
    output logic [PKT_W-1:0] PKT_DATA,
    output logic             BUSY,
    output logic             OVF,
    output logic             TMO
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        ACK_SYNC < 2 || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("ddp_btn_injector: illegal parameter set");
    end

    logic [BTN_W-1:0]    prev_lvl_r;
    logic [SEQ_W-1:0]    seq_r;
    logic [ACK_SYNC-1:0] ack_sync_r;
    inj_state_e          state_r;
    logic                send_r;
    logic [PKT_W-1:0]    pkt_r;
    logic                busy_r;
    logic                ovf_r;

    logic [BTN_W-1:0]    chg_s;
    logic                ack_s;
    logic                push_s;
    logic                pop_s;
    logic                accept_s;
    logic                drop_s;
    logic                leave_rel_s;
    logic                tmo_hit_s;
    logic                full_s;
    logic                empty_s;
    logic [PKT_W-1:0]    head_s;

    assign ack_s       = ack_sync_r[ACK_SYNC-1];
    assign chg_s       = BTN_LVL ^ prev_lvl_r;
    assign push_s      = !RST && (chg_s != {BTN_W{1'b0}});
    assign leave_rel_s = (state_r == ST_RELEASE) && !ack_s;
    assign pop_s       = leave_rel_s || tmo_hit_s;
    assign accept_s    = push_s && (!full_s || pop_s);
    assign drop_s      = push_s && full_s && !pop_s;

    ddp_inj_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push_s),
        .wdata (pack_pkt(seq_r, chg_s, BTN_LVL)),
        .pop   (pop_s),
        .full  (full_s),
        .empty (empty_s),
        .head  (head_s)
    );

    // Ack synchroniser shift chain.
    always_ff @(posedge CLK) begin
        if (RST) ack_sync_r <= {ACK_SYNC{1'b0}};
        else     ack_sync_r <= {ack_sync_r[ACK_SYNC-2:0], Ack_in_DDP};
    end

    // Edge detect and sequence numbering; prev_lvl tracks input in reset so release is silent.
    always_ff @(posedge CLK) begin
        prev_lvl_r <= BTN_LVL;
        if (RST) begin
            seq_r <= {SEQ_W{1'b0}};
        end else if (accept_s) begin
            seq_r <= seq_r + {{(SEQ_W-1){1'b0}}, 1'b1};
        end
    end

    // Handshake FSM with registered Send, data, busy and overflow flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            send_r  <= 1'b0;
            pkt_r   <= {PKT_W{1'b0}};
            busy_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            busy_r <= (state_r != ST_IDLE) || !empty_s;
            if (drop_s) ovf_r <= 1'b1;
            if (tmo_hit_s) begin
                send_r  <= 1'b0;
                state_r <= ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        // A stale high ack must fall before a new request goes out.
                        if (!empty_s && !ack_s) begin
                            pkt_r   <= head_s;
                            send_r  <= 1'b1;
                            state_r <= ST_SEND;
                        end
                    end
                    ST_SEND: begin
                        if (ack_s) begin
                            send_r  <= 1'b0;
                            state_r <= ST_RELEASE;
                        end
                    end
                    ST_RELEASE: begin
                        if (!ack_s) state_r <= ST_IDLE;
                    end
                    default: begin
                        send_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef DDP_INJ_TIMEOUT_EN
    logic [31:0] tmo_cnt_r;
    logic        tmo_r;

    assign tmo_hit_s = (state_r != ST_IDLE) && (tmo_cnt_r == 32'(TIMEOUT_CYC - 1));

    // Per-state dwell counter; restarts whenever the FSM changes state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tmo_cnt_r <= 32'd0;
            tmo_r     <= 1'b0;
        end else begin
            if (state_r == ST_IDLE || ((state_r == ST_SEND) && ack_s) || leave_rel_s || tmo_hit_s)
                tmo_cnt_r <= 32'd0;
            else
                tmo_cnt_r <= tmo_cnt_r + 32'd1;
            if (tmo_hit_s) tmo_r <= 1'b1;
        end
    end

    assign TMO = tmo_r;
`else
    assign tmo_hit_s = 1'b0;
    assign TMO       = 1'b0;
`endif

    assign Send_in_DDP = send_r;
    assign PKT_DATA    = pkt_r;
    assign BUSY        = busy_r;
    assign OVF         = ovf_r;

endmodule

// File: tb/tb_ddp_btn_injector.sv
// Directed self-checking bench for ddp_btn_injector; covers both builds of DDP_INJ_TIMEOUT_EN.
module tb_ddp_btn_injector;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  BTN_LVL;
    logic        Ack_in_DDP;
    logic        Send_in_DDP;
    logic [15:0] PKT_DATA;
    logic        BUSY;
    logic        OVF;
    logic        TMO;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    ddp_btn_injector #(
        .FIFO_DEPTH  (4),
        .ACK_SYNC    (2),
        .TIMEOUT_CYC (16)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .BTN_LVL     (BTN_LVL),
        .Ack_in_DDP  (Ack_in_DDP),
        .Send_in_DDP (Send_in_DDP),
        .PKT_DATA    (PKT_DATA),
        .BUSY        (BUSY),
        .OVF         (OVF),
        .TMO         (TMO)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic [3:0] lvl, input logic ack);
        RST        = 1'b1;
        BTN_LVL    = lvl;
        Ack_in_DDP = ack;
        tick(); tick(); tick();
        RST = 1'b0;
    endtask

    // Waits for a request, checks data, acks it, releases; optionally changes BTN so the push lands on the pop edge.
    task automatic serve(input string tag, input logic [15:0] exp, input bit inject, input logic [3:0] inj_lvl);
        int n;
        n = 0;
        while (Send_in_DDP !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check1({tag, " send_rise"}, Send_in_DDP, 1'b1);
        check16({tag, " pkt"}, PKT_DATA, exp);
        tick(); tick();
        Ack_in_DDP = 1'b1;
        n = 0;
        while (Send_in_DDP !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        check16({tag, " ack_to_fall"}, 16'(n), 16'd3);
        check16({tag, " pkt_hold"}, PKT_DATA, exp);
        Ack_in_DDP = 1'b0;
        tick(); tick();
        if (inject) BTN_LVL = inj_lvl;
        tick();
    endtask

    initial begin
        int n;
        logic [15:0] exp_pkt;

        // Reset state
        RST = 1'b1; BTN_LVL = 4'b0000; Ack_in_DDP = 1'b0;
        tick(); tick();
        check1("rst send", Send_in_DDP, 1'b0);
        check16("rst pkt", PKT_DATA, 16'h0000);
        check1("rst busy", BUSY, 1'b0);
        check1("rst ovf", OVF, 1'b0);
        check1("rst tmo", TMO, 1'b0);
        tick();
        RST = 1'b0;

        // T1: single event, 2-cycle latency, full handshake
        tick();
        BTN_LVL = 4'b0001;
        tick();
        check1("t1 send_early", Send_in_DDP, 1'b0);
        tick();
        check1("t1 send_lat2", Send_in_DDP, 1'b1);
        check1("t1 busy", BUSY, 1'b1);
        serve("t1", 16'h0011, 1'b0, 4'b0000);
        tick();
        check1("t1 busy_clear", BUSY, 1'b0);
        check1("t1 send_idle", Send_in_DDP, 1'b0);
        check16("t1 pkt_kept", PKT_DATA, 16'h0011);

        // T2: two bits in one cycle -> one packet, then seq=1
        do_reset(4'b0000, 1'b0);
        BTN_LVL = 4'b0110;
        serve("t2", 16'h0066, 1'b0, 4'b0000);
        BTN_LVL = 4'b0111;
        serve("t2 seq1", 16'h0117, 1'b0, 4'b0000);
        tick();
        check1("t2 ovf", OVF, 1'b0);

        // T3: overflow with ack low, then in-order drain; push on a full-FIFO pop edge is accepted
        do_reset(4'b0000, 1'b0);
        BTN_LVL = 4'b0001; tick();
        BTN_LVL = 4'b0011; tick();
        BTN_LVL = 4'b0111; tick();
        BTN_LVL = 4'b1111; tick();
        check1("t3 ovf_not_yet", OVF, 1'b0);
        BTN_LVL = 4'b1110; tick();
        BTN_LVL = 4'b1100; tick();
        check1("t3 ovf", OVF, 1'b1);
        check1("t3 busy", BUSY, 1'b1);
        serve("t3 p0", 16'h0011, 1'b1, 4'b1101);
        serve("t3 p1", 16'h0123, 1'b0, 4'b0000);
        serve("t3 p2", 16'h0247, 1'b0, 4'b0000);
        serve("t3 p3", 16'h038F, 1'b0, 4'b0000);
        serve("t3 p4", 16'h041D, 1'b0, 4'b0000);
        tick(); tick();
        check1("t3 busy_end", BUSY, 1'b0);
        check1("t3 ovf_sticky", OVF, 1'b1);

        // T4: reset mid-handshake
        do_reset(4'b0000, 1'b0);
        BTN_LVL = 4'b0001; tick();
        BTN_LVL = 4'b0011; tick();
        check1("t4 send_up", Send_in_DDP, 1'b1);
        RST = 1'b1; BTN_LVL = 4'b1010;
        tick();
        check1("t4 send_drop", Send_in_DDP, 1'b0);
        check16("t4 pkt_clr", PKT_DATA, 16'h0000);
        RST = 1'b0;
        tick(); tick(); tick(); tick();
        check1("t4 no_event", Send_in_DDP, 1'b0);
        check1("t4 fifo_empty", BUSY, 1'b0);
        BTN_LVL = 4'b1011;
        serve("t4 seq0", 16'h001B, 1'b0, 4'b0000);

        // T5: ack never returns
        do_reset(4'b0000, 1'b0);
        BTN_LVL = 4'b0001; tick();
        BTN_LVL = 4'b0011; tick();
        check1("t5 send_up", Send_in_DDP, 1'b1);
        n = 0;
        while (Send_in_DDP === 1'b1 && n < 60) begin
            tick();
            n++;
        end
`ifdef DDP_INJ_TIMEOUT_EN
        check16("t5 tmo_cycles", 16'(n), 16'd16);
        check1("t5 tmo", TMO, 1'b1);
        serve("t5 next", 16'h0123, 1'b0, 4'b0000);
`else
        check16("t5 wait_forever", 16'(n), 16'd60);
        check1("t5 tmo_tied", TMO, 1'b0);
        serve("t5 p0", 16'h0011, 1'b0, 4'b0000);
        serve("t5 p1", 16'h0123, 1'b0, 4'b0000);
`endif

        // T6: ack high across reset release, then sequence wrap
        do_reset(4'b0000, 1'b1);
        tick();
        BTN_LVL = 4'b0101;
        tick(); tick(); tick(); tick(); tick(); tick();
        check1("t6 send_held", Send_in_DDP, 1'b0);
        check1("t6 busy", BUSY, 1'b1);
        Ack_in_DDP = 1'b0;
        n = 0;
        while (Send_in_DDP !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check16("t6 ack_fall_lat", 16'(n), 16'd3);
        serve("t6", 16'h0055, 1'b0, 4'b0000);
        for (int i = 1; i <= 256; i++) begin
            BTN_LVL = BTN_LVL ^ 4'b0001;
            exp_pkt = {8'(i), 4'b0001, BTN_LVL};
            serve("t6 wrap", exp_pkt, 1'b0, 4'b0000);
        end
        check1("t6 ovf", OVF, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
